// File: rtl/neuron_par_mac.sv
// neuron_par_mac
//   Multi-lane fully-connected neuron. Each accepted beat carries `lanes`
//   signed inputs that are multiplied against a run-time-loaded weight store.
//   The lane products are summed and then accumulated with saturation. When a
//   vector of numWeight/lanes beats is complete, the bias is added (also with
//   saturation) and the selected activation is registered onto `out`.
//
// Ports
//   clk                in   single rising-edge clock
//   rst                in   asynchronous, active-low reset
//   myinput            in   lanes*dataWidth; lane k at [k*dataWidth +: dataWidth]
//   myinputValid       in   a beat is offered
//   myinputReady       out  beat accepted on an edge where valid && ready
//   weightValid        in   weight write strobe (honoured only in IDLE)
//   biasValid          in   bias write strobe (honoured only in IDLE)
//   weightValue        in   32; low dataWidth bits used
//   biasValue          in   32; low dataWidth bits used
//   config_layer_num   in   write target layer, matched against layerNo
//   config_neuron_num  in   write target neuron, matched against neuronNo
//   out                out  activated result, held until the next outvalid
//   outvalid           out  one-cycle pulse qualifying out
module neuron_par_mac #(
  parameter int    layerNo        = 1,
  parameter int    neuronNo       = 0,
  parameter int    numWeight      = 784,
  parameter int    lanes          = 4,
  parameter int    dataWidth      = 16,
  parameter int    weightIntWidth = 1,
  parameter int    sigmoidSize    = 10,
  parameter string actType        = "relu"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [lanes*dataWidth-1:0]   myinput,
  input  logic                         myinputValid,
  output logic                         myinputReady,
  input  logic                         weightValid,
  input  logic                         biasValid,
  input  logic [31:0]                  weightValue,
  input  logic [31:0]                  biasValue,
  input  logic [31:0]                  config_layer_num,
  input  logic [31:0]                  config_neuron_num,
  output logic [dataWidth-1:0]         out,
  output logic                         outvalid
);

  localparam int B    = numWeight / lanes;
  localparam int AW   = 2 * dataWidth;
  localparam int SW   = AW + $clog2(lanes);
  localparam int EW   = SW + 1;
  localparam int S    = AW - 1 - weightIntWidth;
  localparam int WPW  = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int BW   = (B > 1) ? $clog2(B) : 1;
  localparam bit IS_SIG  = (actType == "sigmoid");
  localparam bit IS_RELU = (actType == "relu");

  localparam logic signed [AW-1:0]        MAXA = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0]        MINA = {1'b1, {(AW-1){1'b0}}};
  localparam logic        [dataWidth-1:0] MAXO = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic        [dataWidth-1:0] MINO = {1'b1, {(dataWidth-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_DRAIN, S_BIAS, S_SIGRD, S_ACT
  } state_t;

  // Clamp a wide signed sum into the 2*dataWidth accumulator range.
  function automatic logic signed [AW-1:0] sat_aw(input logic signed [EW-1:0] t);
    if (t[EW-1:AW-1] == {(EW-AW+1){t[EW-1]}}) return t[AW-1:0];
    else if (t[EW-1])                        return MINA;
    else                                     return MAXA;
  endfunction

  // ReLU / pass-through: take the dataWidth slice whose MSB sits just below
  // the integer bits of the product format, saturating when it overflows.
  function automatic logic [dataWidth-1:0] act_fn(input logic signed [AW-1:0] v);
    logic [AW-S-1:0] top;
    top = v[AW-1:S];
    if (IS_RELU) begin
      if (v[AW-1])  return '0;
      else if (|top) return MAXO;
      else           return v[S -: dataWidth];
    end else begin
      if (top == {(AW-S){v[AW-1]}}) return v[S -: dataWidth];
      else if (v[AW-1])             return MINO;
      else                          return MAXO;
    end
  endfunction

  // Sigmoid table contents: hard sigmoid 0.5 + x/4 clamped to [0, 1),
  // where x is the address read as a signed fraction of full scale and
  // 1.0 corresponds to 2^(dataWidth-1).
  function automatic logic [dataWidth-1:0] sig_rom(input logic [sigmoidSize-1:0] a);
    int x;
    int y;
    x = int'($signed(a));
    y = (1 <<< (dataWidth - 2)) + ((x * (1 <<< dataWidth)) >>> (sigmoidSize + 2));
    if (y < 0) y = 0;
    if (y > (1 <<< (dataWidth - 1)) - 1) y = (1 <<< (dataWidth - 1)) - 1;
    return dataWidth'(y);
  endfunction

  state_t                        r_state;
  logic                          r_ready;
  logic                          r_outvalid;
  logic [dataWidth-1:0]          r_out;
  logic [BW-1:0]                 r_beat;
  logic [WPW-1:0]                r_wptr;
  logic signed [dataWidth-1:0]   r_bias;
  logic signed [AW-1:0]          r_acc;
  logic signed [AW-1:0]          r_sum;
  logic [dataWidth-1:0]          r_rom;

  logic                          vld_p0, vld_p1, vld_p2, vld_p3;
  logic                          last_p0, last_p1, last_p2, last_p3;
  logic [BW-1:0]                 r_beat_p0;
  logic signed [dataWidth-1:0]   r_x_p0    [lanes];
  logic signed [dataWidth-1:0]   r_x_p1    [lanes];
  logic signed [dataWidth-1:0]   r_w_p1    [lanes];
  logic signed [AW-1:0]          r_prod_p2 [lanes];
  logic signed [SW-1:0]          r_lsum_p3;
  logic signed [dataWidth-1:0]   r_wmem    [numWeight];

  logic                          w_cfg_hit;
  logic                          w_wr_w;
  logic                          w_wr_b;
  logic                          w_accept;
  logic                          w_last_beat;
  logic signed [SW-1:0]          w_lsum;
  logic signed [AW-1:0]          w_bias_sh;
  logic                          w_unused_bits;

  assign myinputReady = r_ready;
  assign out          = r_out;
  assign outvalid     = r_outvalid;

  assign w_cfg_hit   = (config_layer_num  == 32'(layerNo)) &&
                       (config_neuron_num == 32'(neuronNo)) &&
                       (r_state == S_IDLE);
  assign w_wr_w      = weightValid && w_cfg_hit;
  assign w_wr_b      = biasValid   && w_cfg_hit;
  assign w_accept    = myinputValid && r_ready;
  assign w_last_beat = (r_beat == BW'(B - 1));
  assign w_bias_sh   = {r_bias, {dataWidth{1'b0}}};
  assign w_unused_bits = ^{weightValue[31:dataWidth], biasValue[31:dataWidth]};

  always_comb begin
    w_lsum = '0;
    for (int k = 0; k < lanes; k++) w_lsum = w_lsum + SW'(r_prod_p2[k]);
  end

  // Datapath registers and weight store: no reset, qualified by vld_pN.
  always_ff @(posedge clk) begin
    // p0: capture accepted beat and its beat index
    if (w_accept) begin
      for (int k = 0; k < lanes; k++) r_x_p0[k] <= myinput[k*dataWidth +: dataWidth];
      r_beat_p0 <= r_beat;
    end
    // p1: registered weight read, lane k pairs with weight beat*lanes+k
    for (int k = 0; k < lanes; k++) begin
      r_x_p1[k] <= r_x_p0[k];
      r_w_p1[k] <= r_wmem[WPW'(32'(r_beat_p0) * lanes + k)];
    end
    // p2: full-precision lane products
    for (int k = 0; k < lanes; k++) r_prod_p2[k] <= AW'(r_x_p1[k]) * AW'(r_w_p1[k]);
    // p3: lane sum
    r_lsum_p3 <= w_lsum;
    if (w_wr_w) r_wmem[r_wptr] <= weightValue[dataWidth-1:0];
    r_rom <= sig_rom(r_sum[AW-1 -: sigmoidSize]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_outvalid <= 1'b0;
      r_out      <= '0;
      r_beat     <= '0;
      r_wptr     <= '0;
      r_bias     <= '0;
      r_acc      <= '0;
      r_sum      <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      last_p0    <= 1'b0;
      last_p1    <= 1'b0;
      last_p2    <= 1'b0;
      last_p3    <= 1'b0;
    end else begin
      r_outvalid <= 1'b0;
      vld_p0  <= w_accept;
      last_p0 <= w_accept && w_last_beat;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      vld_p3  <= vld_p2;
      last_p3 <= last_p2;

      if (w_wr_w) r_wptr <= (r_wptr == WPW'(numWeight - 1)) ? '0 : r_wptr + 1'b1;
      if (w_wr_b) r_bias <= biasValue[dataWidth-1:0];

      // p4: saturating accumulate; IDLE clears so vectors never carry over
      if (vld_p3)                 r_acc <= sat_aw(EW'(r_acc) + EW'(r_lsum_p3));
      else if (r_state == S_IDLE) r_acc <= '0;

      case (r_state)
        S_IDLE: begin
          r_beat  <= '0;
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_last_beat) begin
              r_state <= S_DRAIN;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_ACCUM;
              r_beat  <= r_beat + 1'b1;
            end
          end
        end
        S_ACCUM: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_last_beat) begin
              r_state <= S_DRAIN;
              r_ready <= 1'b0;
              r_beat  <= '0;
            end else begin
              r_beat  <= r_beat + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          r_ready <= 1'b0;
          if (vld_p3 && last_p3) r_state <= S_BIAS;
        end
        S_BIAS: begin
          r_ready <= 1'b0;
          r_sum   <= sat_aw(EW'(r_acc) + EW'(w_bias_sh));
          r_state <= IS_SIG ? S_SIGRD : S_ACT;
        end
        S_SIGRD: begin
          r_ready <= 1'b0;
          r_state <= S_ACT;
        end
        S_ACT: begin
          r_ready    <= 1'b0;
          r_out      <= IS_SIG ? r_rom : act_fn(r_sum);
          r_outvalid <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_par_mac.sv
// Testbench for neuron_par_mac: two instances (relu and pass-through) share
// all inputs; directed vectors with hand-computed expected outputs.
module tb_neuron_par_mac;

  localparam int DW = 16;
  localparam int LN = 2;
  localparam int NW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [LN*DW-1:0]  myinput = '0;
  logic              myinputValid = 1'b0;
  logic              weightValid = 1'b0;
  logic              biasValid = 1'b0;
  logic [31:0]       weightValue = '0;
  logic [31:0]       biasValue = '0;
  logic [31:0]       config_layer_num = 32'd1;
  logic [31:0]       config_neuron_num = 32'd0;
  logic              rdy_r, rdy_n, ov_r, ov_n;
  logic [DW-1:0]     out_r, out_n;

  int cyc = 0;
  int t_last = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_par_mac #(
    .layerNo(1), .neuronNo(0), .numWeight(NW), .lanes(LN), .dataWidth(DW),
    .weightIntWidth(1), .sigmoidSize(10), .actType("relu")
  ) u_relu (
    .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
    .myinputReady(rdy_r), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .out(out_r), .outvalid(ov_r)
  );

  neuron_par_mac #(
    .layerNo(1), .neuronNo(0), .numWeight(NW), .lanes(LN), .dataWidth(DW),
    .weightIntWidth(1), .sigmoidSize(10), .actType("none")
  ) u_none (
    .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
    .myinputReady(rdy_n), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .out(out_n), .outvalid(ov_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input logic [15:0] v, input int lay, input int neu);
    weightValue       = {16'hA5A5, v};
    config_layer_num  = lay;
    config_neuron_num = neu;
    weightValid       = 1'b1;
    @(posedge clk); #1;
    weightValid       = 1'b0;
    config_layer_num  = 32'd1;
    config_neuron_num = 32'd0;
  endtask

  task automatic wr_b(input logic [15:0] v);
    biasValue = {16'h5A5A, v};
    biasValid = 1'b1;
    @(posedge clk); #1;
    biasValid = 1'b0;
  endtask

  task automatic load4(input logic [15:0] v);
    for (int i = 0; i < 4; i++) wr_w(v, 1, 0);
  endtask

  task automatic send_beat(input logic [15:0] l0, input logic [15:0] l1);
    int w;
    w = 0;
    myinput      = {l1, l0};
    myinputValid = 1'b1;
    while (!rdy_r && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 30) chk("ready_wait", {31'b0, rdy_r}, 32'd1);
    @(posedge clk); #1;
    myinputValid = 1'b0;
    t_last = cyc;
  endtask

  task automatic send_vec(input logic [15:0] x0, input logic [15:0] x1,
                          input logic [15:0] x2, input logic [15:0] x3);
    send_beat(x0, x1);
    send_beat(x2, x3);
  endtask

  task automatic wait_out(input string tag, input logic [15:0] exp_r, input logic [15:0] exp_n);
    int n;
    n = 0;
    while (!ov_r && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_vld"},   {31'b0, ov_r}, 32'd1);
    chk({tag, "_nvld"},  {31'b0, ov_n}, 32'd1);
    chk({tag, "_lat"},   cyc - t_last, 32'd6);
    chk({tag, "_relu"},  {16'b0, out_r}, {16'b0, exp_r});
    chk({tag, "_none"},  {16'b0, out_n}, {16'b0, exp_n});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'b0, ov_r}, 32'd0);
    chk({tag, "_hold"},  {16'b0, out_r}, {16'b0, exp_r});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt, rdy_bad, seen, got, t2, ovc;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {16'b0, out_r}, 32'd0);
    chk("rst_vld", {31'b0, ov_r}, 32'd0);
    chk("rst_rdy", {31'b0, rdy_r}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rdy_rise", {31'b0, rdy_r}, 32'd1);

    // Basic: 4 * (0x4000*0x2000) = 2^29 -> slice [30:15] = 0x4000
    load4(16'h2000);
    wr_b(16'h0000);
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_out("basic", 16'h4000, 16'h4000);

    // Bias 0x1000 << 16 adds 2^28 -> 0x6000, then back-to-back
    wr_b(16'h1000);
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_out("bias", 16'h6000, 16'h6000);
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_out("b2b", 16'h6000, 16'h6000);

    // Positive saturation
    wr_b(16'h0000);
    load4(16'h7FFF);
    send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_out("psat", 16'h7FFF, 16'h7FFF);

    // Negative saturation: relu -> 0, pass-through -> 0x8000
    load4(16'h8000);
    send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_out("nsat", 16'h0000, 16'h8000);

    // ReLU negative: 4 * (-2^29) = -2^31 exactly
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_out("rneg", 16'h0000, 16'h8000);

    // Handshake: valid held high, only two beats accepted
    load4(16'h2000);
    acc_cnt = 0; rdy_bad = 0; seen = 0; got = 0; t2 = 0;
    myinput = {16'h4000, 16'h4000};
    myinputValid = 1'b1;
    for (int i = 0; i < 30 && got == 0; i++) begin
      if (myinputValid && rdy_r) acc_cnt++;
      @(posedge clk); #1;
      if (acc_cnt == 2 && seen == 0) begin seen = 1; t2 = cyc; end
      if (seen != 0 && rdy_r) rdy_bad++;
      if (ov_r) got = 1;
    end
    myinputValid = 1'b0;
    chk("hs_got", got, 32'd1);
    chk("hs_accepted", acc_cnt, 32'd2);
    chk("hs_rdy_low", rdy_bad, 32'd0);
    chk("hs_lat", cyc - t2, 32'd6);
    chk("hs_out", {16'b0, out_r}, 32'h4000);
    @(posedge clk); #1;
    chk("hs_rdy_back", {31'b0, rdy_r}, 32'd1);

    // Weight write during DRAIN is dropped
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wr_w(16'h7FFF, 1, 0);
    wait_out("drain", 16'h4000, 16'h4000);
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_out("drain_after", 16'h4000, 16'h4000);

    // Mismatched neuron / layer IDs leave the weights untouched
    wr_w(16'h7FFF, 1, 5);
    wr_w(16'h7FFF, 2, 0);
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_out("id_filter", 16'h4000, 16'h4000);

    // Fifth write wraps onto index 0: weights {0,0x2000,0x2000,0x2000} -> 0x3000
    load4(16'h2000);
    wr_w(16'h0000, 1, 0);
    send_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_out("wrap", 16'h3000, 16'h3000);
    wr_w(16'h2000, 1, 0);
    wr_w(16'h2000, 1, 0);
    wr_w(16'h2000, 1, 0);

    // Lane ordering: 2^27 + 2^25 + 2^23 + 2^21 -> 0x1540
    wr_w(16'h2000, 1, 0);
    wr_w(16'h1000, 1, 0);
    wr_w(16'h0800, 1, 0);
    wr_w(16'h0400, 1, 0);
    send_vec(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    wait_out("lanes", 16'h1540, 16'h1540);

    // Reset mid-vector
    send_beat(16'h4000, 16'h2000);
    rst = 1'b0;
    ovc = 0;
    rdy_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rdy_r) rdy_bad++;
      if (ov_r) ovc++;
    end
    chk("rstm_rdy", rdy_bad, 32'd0);
    chk("rstm_out", {16'b0, out_r}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov_r) ovc++;
    end
    chk("rstm_novld", ovc, 32'd0);
    send_vec(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    wait_out("rstm_full", 16'h1540, 16'h1540);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_par_mac.md
# neuron_par_mac

Parametrised multi-lane neuron for the fully-connected accelerator, the next generation of the single-lane per-layer neuron. It consumes `lanes` inputs per beat against a run-time-loaded weight store and a run-time-loaded bias, then emits one activated output per input vector. A ready/valid input handshake back-pressures the layer sequencer. Activation is chosen by parameter: sigmoid ROM, ReLU or pass-through.

## Interface
- `layerNo`, 1: layer ID matched against `config_layer_num`.
- `neuronNo`, 0: neuron ID matched against `config_neuron_num`.
- `numWeight`, 784: weights per neuron; must be a multiple of `lanes`.
- `lanes`, 4: inputs/products per beat (1..16); beats per vector B = numWeight/lanes.
- `dataWidth`, 16: signed input/weight/output width.
- `weightIntWidth`, 1: integer bits of the weight format; sets the output slice.
- `sigmoidSize`, 10: sigmoid ROM address width.
- `actType`, "relu": "sigmoid", "relu" or "none".
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `myinput` in lanes*dataWidth: lane k occupies bits [k*dataWidth +: dataWidth]; lane k pairs with weight index beat*lanes+k.
- `myinputValid` in 1: a beat is offered.
- `myinputReady` out 1: the beat is accepted on an edge where valid && ready.
- `weightValid` in 1: weight write strobe.
- `biasValid` in 1: bias write strobe.
- `weightValue` in 32: bits [dataWidth-1:0] are used.
- `biasValue` in 32: bits [dataWidth-1:0] are used.
- `config_layer_num` in 32: write target layer.
- `config_neuron_num` in 32: write target neuron.
- `out` out dataWidth: activated result.
- `outvalid` out 1: one-cycle pulse qualifying `out`.

## Operation
- **Reset values:** `out`=0, `outvalid`=0, `myinputReady`=0; accumulator, bias, weight write pointer and beat counter are 0; FSM is IDLE. Weight store contents are not reset. `myinputReady` rises on the first edge after `rst` deasserts.
- **Weight and bias writes:**
  - A write is accepted only when its strobe is high, `config_layer_num`==layerNo, `config_neuron_num`==neuronNo, and the FSM is IDLE.
  - A write in any other state is dropped.
  - Weight writes go to the write pointer, which then increments and wraps from numWeight-1 to 0.
  - A bias write replaces the bias register.
  - Simultaneous weight and bias writes are both performed.
- **FSM states:**
  - IDLE (ready=1, beat count 0) → ACCUM on the first accepted beat.
  - ACCUM (ready=1) → DRAIN when beat B is accepted.
  - DRAIN (ready=0): wait until the last beat's accumulate stage completes → BIAS.
  - BIAS (ready=0): add bias → ACT.
  - ACT (ready=0): register the activation, pulse `outvalid` → IDLE.
  - When B==1, the first accepted beat goes directly to DRAIN.
- **Pipeline per beat:** weight read (registered) → lanes signed products of 2*dataWidth each → full-precision lane adder tree (2*dataWidth+clog2(lanes) bits) → saturating accumulate.
- **Accumulator:** 2*dataWidth signed. acc = sat(acc + laneSum), clamped to [0x8000…0, 0x7FFF…F].
- **Bias add:** sum = sat(acc + (bias << dataWidth)), same clamp.
- **Activation** (s = 2*dataWidth-1-weightIntWidth):
  - relu: sum<0 → 0; any of bits [2*dataWidth-1:s] set → max positive; otherwise sum[s -: dataWidth].
  - none: the same signed slice, saturating both directions.
  - sigmoid: the existing ROM addressed by sum[2*dataWidth-1 -: sigmoidSize].
- **Per-vector clearing:** the accumulator clears in IDLE, so there is no carry-over between vectors.
- **Reset mid-vector:** aborts immediately. No `outvalid` is produced and the partial vector is discarded.

## Timing
- Beat accepted at edge 0 → weight read at 1 → products at 2 → lane sum at 3 → accumulated at 4.
- Last beat accepted at edge T → DRAIN through T+4 → bias at T+5 → `out`/`outvalid` at edge T+6. The sigmoid ROM adds one further cycle, giving T+7.
- Throughput: one beat per cycle in ACCUM, with gaps allowed (valid low holds the counter).
- `myinputReady` falls on the edge that accepts beat B. It rises on the edge after `outvalid`.
- `outvalid` is high exactly one cycle. `out` holds its value until the next `outvalid`.

## Test plan
- **Basic ReLU vector** (lanes=2, numWeight=4, dataWidth=16, relu, weightIntWidth=1): load weights 0x2000 ×4 and bias 0, send 2 beats of {0x4000,0x4000} → `outvalid` 6 cycles after the last beat, `out`=0x4000.
- **Bias applied:** same setup with bias 0x1000 → `out`=0x6000. Repeat the vector back-to-back → the same 0x6000, proving the accumulator cleared.
- **Positive saturation:** weights 0x7FFF, inputs 0x7FFF → the accumulator clamps to 0x7FFFFFFF and `out`=0x7FFF. With actType="none", weights 0x8000 and inputs 0x7FFF → `out`=0x8000.
- **ReLU negative:** weights 0x8000, inputs 0x4000 → `out`=0x0000, `outvalid` still pulses.
- **Handshake and ID filtering:**
  - Hold `myinputValid` high with 3 extra beats → only 2 are accepted; `myinputReady` is low from acceptance of beat 2 until the cycle after `outvalid`.
  - A weight write during DRAIN is dropped.
  - A write with a mismatched neuron ID leaves the weights unchanged.
  - A 5th weight write wraps and overwrites index 0.
- **Reset mid-vector:** assert `rst` low after beat 1 → no `outvalid`, `myinputReady`=0 while reset is held. After release, a full vector gives the correct result.
